// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg
//   Shared types and constants for the FIFO write-port arbiter.
//   Build option: FIFO_WR_ARB_BURST_EN selects the burst limit. When it is
//   defined an owner may write up to MAX_BURST words per grant. When it is not,
//   every grant covers a single word.
package fifo_wr_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Width of an index into n items. The minimum is 1 bit so that n == 1 is legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

`ifdef FIFO_WR_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    // Number of accepted beats per grant.
    function automatic int burst_limit(input int max_burst);
        return BURST_EN ? max_burst : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if
//   Bundle of the requester handshake and the FIFO write-side signals.
//   Build option: none. Widths follow the NUM_REQ and DATA_WIDTH parameters.
//   master : producers and FIFO side. It drives req_valid, req_data and Full_.
//   slave  : the arbiter. It drives req_ready, WriteEn, DataIn, grant_valid
//            and grant_id.
interface fifo_wr_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    import fifo_wr_arb_pkg::*;

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          Full_;
    logic                          WriteEn;
    logic [DATA_WIDTH-1:0]         DataIn;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;

    modport master (
        output req_valid, req_data, Full_,
        input  req_ready, WriteEn, DataIn, grant_valid, grant_id
    );

    modport slave (
        input  req_valid, req_data, Full_,
        output req_ready, WriteEn, DataIn, grant_valid, grant_id
    );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// fifo_wr_arb_rr_pick
//   Combinational round-robin selector. The scan starts at base+1 (mod
//   NUM_REQ) and wraps, so base itself is checked last.
//   Build option: none.
//   req        : request vector
//   base       : round-robin pointer (the previous owner)
//   excl_en    : base is eligible only when no other index is requesting
//   pick_valid : at least one eligible request
//   pick_id    : selected index, 0 when pick_valid is 0
module fifo_wr_arb_rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    base,
    input  logic               excl_en,
    output logic               pick_valid,
    output logic [ID_W-1:0]    pick_id
);

    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] masked;
    int                 idx;

    always_comb begin
        others     = req & ~(NUM_REQ'(1) << base);
        masked     = (excl_en && (|others)) ? others : req;
        pick_valid = |masked;
        pick_id    = '0;
        idx        = 0;
        // Scan from the farthest offset to the nearest one, so the
        // assignment that survives is the nearest index after base.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(base) + k) % NUM_REQ;
            if (masked[idx]) begin
                pick_id = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
//   Round-robin arbiter that shares the single write port of one FIFO among
//   NUM_REQ producers. Producers connect through valid/ready handshakes. The
//   arbiter drives the FIFO WriteEn/DataIn strobe and never writes while Full_
//   is low.
//   Build option: FIFO_WR_ARB_BURST_EN. When it is defined, an owner keeps the
//   grant for up to MAX_BURST accepted beats. When it is not defined, the grant
//   rotates after every beat.
//   Clock  : rising-edge clock
//   Reset_ : asynchronous reset, active low
//   bus    : handshake and FIFO signals (fifo_wr_arb_if.slave)
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ARB_IDLE  | no owner; arbitrate when any req_valid is set
//   ARB_GRANT | owner holds the write port; beat_cnt counts beats
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic        Clock,
    input  logic        Reset_,
    fifo_wr_arb_if.slave bus
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int LIMIT = burst_limit(MAX_BURST);

    arb_state_e      state, state_nxt;
    logic [ID_W-1:0] owner, owner_nxt;
    logic [ID_W-1:0] last_owner, last_nxt;

    logic            granted;
    logic            owner_valid;
    logic            accept;
    logic            last_beat;
    logic            release_now;
    logic [ID_W-1:0] pick_base;
    logic            pick_valid;
    logic [ID_W-1:0] pick_id;

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int BW = id_width(LIMIT);
    logic [BW-1:0] beat_cnt, beat_nxt;
    assign last_beat = (beat_cnt == BW'(LIMIT - 1));
`else
    assign last_beat = (LIMIT == 1);
`endif

    assign granted     = (state == ARB_GRANT);
    assign owner_valid = bus.req_valid[owner];
    assign accept      = granted & bus.Full_ & owner_valid;
    // A full FIFO freezes the grant, including a grant whose owner has dropped.
    assign release_now = granted & bus.Full_ & (~owner_valid | (accept & last_beat));

    // In GRANT the scan starts after the current owner. That value becomes
    // last_owner at the edge where the owner releases.
    assign pick_base = granted ? owner : last_owner;

    fifo_wr_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (bus.req_valid),
        .base       (pick_base),
        .excl_en    (granted),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            last_owner <= ID_W'(NUM_REQ - 1);
`ifdef FIFO_WR_ARB_BURST_EN
            beat_cnt   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_nxt;
`ifdef FIFO_WR_ARB_BURST_EN
            beat_cnt   <= beat_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_owner;
`ifdef FIFO_WR_ARB_BURST_EN
        beat_nxt  = beat_cnt;
`endif
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ARB_GRANT;
                    owner_nxt = pick_id;
`ifdef FIFO_WR_ARB_BURST_EN
                    beat_nxt  = '0;
`endif
                end
            end
            ARB_GRANT: begin
                if (release_now) begin
                    last_nxt = owner;
`ifdef FIFO_WR_ARB_BURST_EN
                    beat_nxt = '0;
`endif
                    if (pick_valid) begin
                        owner_nxt = pick_id;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end else if (accept) begin
`ifdef FIFO_WR_ARB_BURST_EN
                    beat_nxt = beat_cnt + BW'(1);
`endif
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.req_ready   = '0;
        bus.WriteEn     = 1'b0;
        bus.DataIn      = '0;
        bus.grant_valid = 1'b0;
        bus.grant_id    = '0;
        if (granted) begin
            bus.grant_valid = 1'b1;
            bus.grant_id    = owner;
            if (bus.Full_) begin
                bus.req_ready[owner] = 1'b1;
            end
        end
        if (accept) begin
            bus.WriteEn = 1'b1;
            bus.DataIn  = bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb
//   Self-checking bench for fifo_wr_arb. A cycle-level reference model tracks
//   the owner, the round-robin pointer and the beat count. The model picks
//   owners with a modular scan.
//   Build option: FIFO_WR_ARB_BURST_EN (sets the expected burst limit).
module tb_fifo_wr_arb;
    import fifo_wr_arb_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int MB  = 4;
    localparam int IDW = id_width(N);
`ifdef FIFO_WR_ARB_BURST_EN
    localparam int LIMIT = MB;
`else
    localparam int LIMIT = 1;
`endif

    logic Clock = 1'b0;
    logic Reset_;
    always #5 Clock = ~Clock;

    fifo_wr_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .Clock  (Clock),
        .Reset_ (Reset_),
        .bus    (bus.slave)
    );

    logic [N-1:0]  v = '0;
    logic [DW-1:0] d [N];
    logic          full_n = 1'b1;

    always_comb begin
        bus.req_valid = v;
        bus.Full_     = full_n;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = d[i];
    end

    // reference model state
    bit m_grant;
    int m_owner, m_last, m_beat;
    // expected outputs for the current cycle
    logic [N-1:0]   e_ready;
    logic           e_we;
    logic [DW-1:0]  e_data;
    logic           e_gv;
    logic [IDW-1:0] e_gid;
    logic [N-1:0]   acc;

    int total = 0;
    int bad   = 0;

    function automatic int rr(input logic [N-1:0] vv, input int start);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (vv[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_grant = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_beat  = 0;
    endfunction

    function automatic void calc_exp();
        e_ready = '0;
        e_we    = 1'b0;
        e_data  = '0;
        e_gv    = m_grant;
        e_gid   = m_grant ? IDW'(m_owner) : '0;
        if (m_grant && full_n) begin
            e_ready[m_owner] = 1'b1;
            if (v[m_owner]) begin
                e_we   = 1'b1;
                e_data = d[m_owner];
            end
        end
        acc = e_we ? (N'(1) << m_owner) : '0;
    endfunction

    function automatic void model_advance();
        bit a, r;
        int p;
        if (!m_grant) begin
            p = rr(v, m_last);
            if (p >= 0) begin
                m_grant = 1'b1;
                m_owner = p;
                m_beat  = 0;
            end
        end else begin
            a = full_n && v[m_owner];
            r = full_n && (!v[m_owner] || (a && (m_beat == LIMIT - 1)));
            if (r) begin
                m_last = m_owner;
                m_beat = 0;
                p = rr(v, m_owner);
                if (p >= 0) m_owner = p;
                else        m_grant = 1'b0;
            end else if (a) begin
                m_beat++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge Clock);
        model_advance();
        #1;
    endtask

    task automatic apply_reset();
        Reset_ = 1'b0;
        model_reset();
        v      = '0;
        full_n = 1'b1;
        for (int i = 0; i < N; i++) d[i] = '0;
        repeat (2) @(posedge Clock);
        #1;
        Reset_ = 1'b1;
    endtask

    function automatic void rand_update(input logic [N-1:0] ac);
        for (int i = 0; i < N; i++) begin
            if (ac[i] || !v[i]) begin
                if ($urandom_range(99) < 60) begin
                    v[i] = 1'b1;
                    d[i] = $urandom;
                end else begin
                    v[i] = 1'b0;
                end
            end else if ($urandom_range(99) < 5) begin
                v[i] = 1'b0;
            end
        end
        full_n = ($urandom_range(99) < 75);
    endfunction

    task automatic test_reset();
        Reset_ = 1'b0;
        model_reset();
        v      = '1;
        full_n = 1'b1;
        for (int i = 0; i < N; i++) d[i] = $urandom;
        #3;
        calc_exp();
        total++;
        if ({bus.req_ready, bus.WriteEn, bus.DataIn, bus.grant_valid, bus.grant_id} !==
            {e_ready, e_we, e_data, e_gv, e_gid}) begin
            bad++;
            $display("FAIL reset_hold ready=%b exp %b we=%b exp %b data=%h exp %h gv=%b exp %b",
                     bus.req_ready, e_ready, bus.WriteEn, e_we, bus.DataIn, e_data, bus.grant_valid, e_gv);
        end
        @(posedge Clock);
        #1;
        Reset_ = 1'b1;
        #2;
        total++;
        if (bus.grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release grant_valid=%b exp 0", bus.grant_valid);
        end
        tick();
        total++;
        if (bus.grant_valid !== 1'b1 || bus.grant_id !== IDW'(0)) begin
            bad++;
            $display("FAIL first_pick gv=%b gid=%0d exp gv=1 gid=0", bus.grant_valid, bus.grant_id);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] got[$];
        int nxt = 1;
        apply_reset();
        v[0] = 1'b1;
        d[0] = 32'hA0;
        for (int c = 0; c < 7; c++) begin
            #2;
            calc_exp();
            total++;
            if ({bus.req_ready, bus.WriteEn, bus.DataIn, bus.grant_valid, bus.grant_id} !==
                {e_ready, e_we, e_data, e_gv, e_gid}) begin
                bad++;
                $display("FAIL single c=%0d ready=%b exp %b we=%b exp %b data=%h exp %h gid=%0d exp %0d",
                         c, bus.req_ready, e_ready, bus.WriteEn, e_we, bus.DataIn, e_data, bus.grant_id, e_gid);
            end
            if (c == 1) begin
                total++;
                if (bus.grant_valid !== 1'b1 || bus.grant_id !== IDW'(0)) begin
                    bad++;
                    $display("FAIL single_grant gv=%b gid=%0d exp gv=1 gid=0", bus.grant_valid, bus.grant_id);
                end
            end
            if (bus.WriteEn === 1'b1) got.push_back(bus.DataIn);
            tick();
            if (acc[0]) begin
                if (nxt < 3) begin
                    d[0] = 32'hA0 + DW'(nxt);
                    nxt++;
                end else begin
                    v[0] = 1'b0;
                end
            end
        end
        total++;
        if (got.size() != 3) begin
            bad++;
            $display("FAIL single_count writes=%0d exp 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (got[k] !== 32'hA0 + DW'(k)) begin
                    bad++;
                    $display("FAIL single_data k=%0d data=%h exp %h", k, got[k], 32'hA0 + DW'(k));
                end
            end
        end
        total++;
        if (bus.grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle grant_valid=%b exp 0", bus.grant_valid);
        end
    endtask

    task automatic test_all_valid();
        int nwr = 0;
        int bubbles = 0;
        apply_reset();
        v = '1;
        for (int i = 0; i < N; i++) d[i] = {8'(i), 24'h0};
        tick();
        for (int c = 0; c < 24; c++) begin
            #2;
            calc_exp();
            total++;
            if ({bus.req_ready, bus.WriteEn, bus.DataIn, bus.grant_valid, bus.grant_id} !==
                {e_ready, e_we, e_data, e_gv, e_gid}) begin
                bad++;
                $display("FAIL all_valid c=%0d we=%b exp %b data=%h exp %h gid=%0d exp %0d",
                         c, bus.WriteEn, e_we, bus.DataIn, e_data, bus.grant_id, e_gid);
            end
            if (bus.WriteEn !== 1'b1) begin
                bubbles++;
            end else begin
                total++;
                if (bus.grant_id !== IDW'((nwr / LIMIT) % N)) begin
                    bad++;
                    $display("FAIL order k=%0d grant_id=%0d exp %0d", nwr, bus.grant_id, (nwr / LIMIT) % N);
                end
                nwr++;
            end
            tick();
            for (int i = 0; i < N; i++) if (acc[i]) d[i] = d[i] + 1;
        end
        total++;
        if (bubbles != 0) begin
            bad++;
            $display("FAIL no_bubble idle_cycles=%0d exp 0", bubbles);
        end
    endtask

    task automatic test_full_stall();
        apply_reset();
        v    = 4'b0100;
        d[2] = 32'hC0DE_0002;
        tick();
        full_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            calc_exp();
            total++;
            if ({bus.req_ready, bus.WriteEn, bus.DataIn, bus.grant_valid, bus.grant_id} !==
                {e_ready, e_we, e_data, e_gv, e_gid}) begin
                bad++;
                $display("FAIL stall_model c=%0d ready=%b exp %b we=%b exp %b gid=%0d exp %0d",
                         c, bus.req_ready, e_ready, bus.WriteEn, e_we, bus.grant_id, e_gid);
            end
            total++;
            if (bus.req_ready !== '0 || bus.WriteEn !== 1'b0 || bus.grant_id !== IDW'(2)) begin
                bad++;
                $display("FAIL stall c=%0d ready=%b we=%b gid=%0d exp ready=0 we=0 gid=2",
                         c, bus.req_ready, bus.WriteEn, bus.grant_id);
            end
            tick();
        end
        full_n = 1'b1;
        #2;
        total++;
        if (bus.WriteEn !== 1'b1 || bus.DataIn !== 32'hC0DE_0002 || bus.req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL stall_resume we=%b data=%h ready=%b exp we=1 data=c0de0002 ready=0100",
                     bus.WriteEn, bus.DataIn, bus.req_ready);
        end
        tick();
        v = '0;
        tick();
    endtask

    task automatic test_drop();
        int n0 = 0;
        apply_reset();
        v[0] = 1'b1;
        d[0] = 32'hB0;
        for (int c = 0; c < 6; c++) begin
            #2;
            calc_exp();
            total++;
            if ({bus.req_ready, bus.WriteEn, bus.DataIn, bus.grant_valid, bus.grant_id} !==
                {e_ready, e_we, e_data, e_gv, e_gid}) begin
                bad++;
                $display("FAIL drop c=%0d we=%b exp %b data=%h exp %h gid=%0d exp %0d",
                         c, bus.WriteEn, e_we, bus.DataIn, e_data, bus.grant_id, e_gid);
            end
            if (c == 4) begin
                total++;
                if (bus.grant_id !== IDW'(3) || bus.WriteEn !== 1'b1 || bus.DataIn !== 32'hD3) begin
                    bad++;
                    $display("FAIL drop_handover gid=%0d we=%b data=%h exp gid=3 we=1 data=d3",
                             bus.grant_id, bus.WriteEn, bus.DataIn);
                end
            end
            tick();
            if (acc[0]) begin
                n0++;
                d[0] = d[0] + 1;
                if (n0 == 2) begin
                    v[0] = 1'b0;
                    v[3] = 1'b1;
                    d[3] = 32'hD3;
                end
            end
            if (acc[3]) v[3] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        v    = 4'b0010;
        d[1] = 32'h11;
        tick();
        tick();
        tick();
        #2;
        Reset_ = 1'b0;
        model_reset();
        v[2]   = 1'b1;
        d[2]   = 32'h22;
        #1;
        total++;
        if (bus.WriteEn !== 1'b0 || bus.req_ready !== '0 || bus.grant_valid !== 1'b0 ||
            bus.grant_id !== '0 || bus.DataIn !== '0) begin
            bad++;
            $display("FAIL async_reset we=%b ready=%b gv=%b gid=%0d data=%h exp all zero",
                     bus.WriteEn, bus.req_ready, bus.grant_valid, bus.grant_id, bus.DataIn);
        end
        @(posedge Clock);
        #1;
        Reset_ = 1'b1;
        tick();
        #2;
        total++;
        if (bus.grant_valid !== 1'b1 || bus.grant_id !== IDW'(1)) begin
            bad++;
            $display("FAIL post_reset_pick gv=%b gid=%0d exp gv=1 gid=1", bus.grant_valid, bus.grant_id);
        end
        v = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            #2;
            calc_exp();
            total++;
            if ({bus.req_ready, bus.WriteEn, bus.DataIn, bus.grant_valid, bus.grant_id} !==
                {e_ready, e_we, e_data, e_gv, e_gid}) begin
                bad++;
                $display("FAIL random c=%0d v=%b full=%b ready=%b exp %b we=%b exp %b data=%h exp %h gv=%b exp %b gid=%0d exp %0d",
                         c, v, full_n, bus.req_ready, e_ready, bus.WriteEn, e_we, bus.DataIn, e_data,
                         bus.grant_valid, e_gv, bus.grant_id, e_gid);
            end
            tick();
            rand_update(acc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_full_stall();
        test_drop();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
